// File: rtl/pe_credit_node.sv
// rtl/pe_credit_node.sv - NoC processing element: credit-flow packet generator plus framing-checking flit sink
module pe_credit_node #(
    parameter int FLIT_W  = 20,
    parameter int CREDITS = 7,
    parameter int PKT_LEN = 4,
    parameter int NODE_ID = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_gen_en,
    input  logic [3:0]        i_dest_in,
    input  logic              i_credit_in,
    output logic [FLIT_W-1:0] o_dataout,
    output logic              o_out_valid,
    input  logic [FLIT_W-1:0] i_datain,
    input  logic              i_in_valid,
    output logic              o_credit_out,
    output logic [15:0]       o_rx_pkt_cnt,
    output logic [3:0]        o_rx_last_src,
    output logic [15:0]       o_tx_pkt_cnt,
    output logic [7:0]        o_credit_cnt,
    output logic [1:0]        o_err
);

    localparam int         PW        = FLIT_W - 2;
    localparam logic [7:0] CRED_MAX  = 8'(CREDITS);
    localparam logic [7:0] LAST_BODY = 8'((PKT_LEN > 2) ? (PKT_LEN - 3) : 0);
    localparam logic [3:0] SRC_ID    = 4'(NODE_ID);

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_body_idx;
    logic [7:0]        w_body_idx_nxt;
    logic [7:0]        r_credit_cnt;
    logic [15:0]       r_tx_pkt_cnt;
    logic [15:0]       r_rx_pkt_cnt;
    logic [3:0]        r_rx_last_src;
    logic [FLIT_W-1:0] r_dataout;
    logic              r_out_valid;
    logic              r_credit_out;
    logic              r_in_pkt;
    logic              r_err_credit;
    logic              r_err_rx;

    logic              w_send;
    logic [FLIT_W-1:0] w_flit;
    logic [PW-1:0]     w_cnt_pl;
    logic [1:0]        w_rx_type;
    logic [3:0]        w_rx_src;

    // A flit leaves only with a credit in hand; otherwise the FSM stalls in place.
    assign w_send = (r_state != S_IDLE) && (r_credit_cnt != 8'd0);

    always_comb begin
        w_cnt_pl = '0;
        for (int i = 0; i < PW; i++) begin
            if (i < 16) w_cnt_pl[i] = r_tx_pkt_cnt[i[3:0]];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_body_idx_nxt = r_body_idx;
        w_flit         = {T_BODY, w_cnt_pl};
        case (r_state)
            S_IDLE: begin
                if (i_gen_en) w_state_nxt = S_HEAD;
            end
            S_HEAD: begin
                w_flit = {T_HEAD, i_dest_in, SRC_ID, {(FLIT_W-10){1'b0}}};
                if (w_send) w_state_nxt = (PKT_LEN > 2) ? S_BODY : S_TAIL;
            end
            S_BODY: begin
                if (w_send) begin
                    if (r_body_idx == LAST_BODY) begin
                        w_state_nxt    = S_TAIL;
                        w_body_idx_nxt = 8'd0;
                    end else begin
                        w_body_idx_nxt = r_body_idx + 8'd1;
                    end
                end
            end
            S_TAIL: begin
                w_flit = {T_TAIL, w_cnt_pl};
                if (w_send) w_state_nxt = i_gen_en ? S_HEAD : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_body_idx   <= 8'd0;
            r_dataout    <= '0;
            r_out_valid  <= 1'b0;
            r_tx_pkt_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_body_idx  <= w_body_idx_nxt;
            r_out_valid <= w_send;
            if (w_send) r_dataout <= w_flit;
            if (w_send && (r_state == S_TAIL)) r_tx_pkt_cnt <= r_tx_pkt_cnt + 16'd1;
        end
    end

    // A return with nothing outstanding is held at the ceiling and flagged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_credit_cnt <= CRED_MAX;
            r_err_credit <= 1'b0;
        end else if (i_credit_in && !w_send) begin
            if (r_credit_cnt == CRED_MAX) r_err_credit <= 1'b1;
            else                          r_credit_cnt <= r_credit_cnt + 8'd1;
        end else if (w_send && !i_credit_in) begin
            r_credit_cnt <= r_credit_cnt - 8'd1;
        end
    end

    assign w_rx_type = i_datain[FLIT_W-1 -: 2];
    assign w_rx_src  = i_datain[FLIT_W-7 -: 4];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_credit_out  <= 1'b0;
            r_in_pkt      <= 1'b0;
            r_rx_pkt_cnt  <= 16'd0;
            r_rx_last_src <= 4'd0;
            r_err_rx      <= 1'b0;
        end else begin
            r_credit_out <= i_in_valid;
            if (i_in_valid) begin
                case (w_rx_type)
                    T_HEAD: begin
                        if (r_in_pkt) r_err_rx <= 1'b1;
                        r_in_pkt      <= 1'b1;
                        r_rx_last_src <= w_rx_src;
                    end
                    T_BODY: begin
                        if (!r_in_pkt) r_err_rx <= 1'b1;
                    end
                    T_TAIL: begin
                        if (r_in_pkt) begin
                            r_rx_pkt_cnt <= r_rx_pkt_cnt + 16'd1;
                            r_in_pkt     <= 1'b0;
                        end else begin
                            r_err_rx <= 1'b1;
                        end
                    end
                    default: r_err_rx <= 1'b1;
                endcase
            end
        end
    end

    assign o_dataout     = r_dataout;
    assign o_out_valid   = r_out_valid;
    assign o_credit_out  = r_credit_out;
    assign o_rx_pkt_cnt  = r_rx_pkt_cnt;
    assign o_rx_last_src = r_rx_last_src;
    assign o_tx_pkt_cnt  = r_tx_pkt_cnt;
    assign o_credit_cnt  = r_credit_cnt;
    assign o_err         = {r_err_rx, r_err_credit};

endmodule

// File: tb/tb_pe_credit_node.sv
// tb/tb_pe_credit_node.sv - self-checking bench for pe_credit_node
module tb_pe_credit_node;

    localparam int FW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          gen_en = 1'b0;
    logic [3:0]    dest_in = 4'd0;
    logic          credit_in = 1'b0;
    logic [FW-1:0] dataout;
    logic          out_valid;
    logic [FW-1:0] datain = '0;
    logic          in_valid = 1'b0;
    logic          credit_out;
    logic [15:0]   rx_pkt_cnt;
    logic [3:0]    rx_last_src;
    logic [15:0]   tx_pkt_cnt;
    logic [7:0]    credit_cnt;
    logic [1:0]    err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pe_credit_node #(.FLIT_W(FW), .CREDITS(7), .PKT_LEN(4), .NODE_ID(9)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_gen_en(gen_en), .i_dest_in(dest_in),
        .i_credit_in(credit_in), .o_dataout(dataout), .o_out_valid(out_valid),
        .i_datain(datain), .i_in_valid(in_valid), .o_credit_out(credit_out),
        .o_rx_pkt_cnt(rx_pkt_cnt), .o_rx_last_src(rx_last_src),
        .o_tx_pkt_cnt(tx_pkt_cnt), .o_credit_cnt(credit_cnt), .o_err(err)
    );

    typedef struct {
        logic          v;
        logic [FW-1:0] d;
        logic          co;
        logic [15:0]   cnt;
        logic [3:0]    src;
        logic          e1;
    } rx_vec_t;

    rx_vec_t vecs[14];

    function automatic logic [FW-1:0] hd(input logic [3:0] dest);
        return {2'b01, dest, 4'd9, 10'd0};
    endfunction
    function automatic logic [FW-1:0] bd(input logic [15:0] c);
        return {2'b00, 2'b00, c};
    endfunction
    function automatic logic [FW-1:0] tl(input logic [15:0] c);
        return {2'b10, 2'b00, c};
    endfunction
    function automatic logic [FW-1:0] rxf(input logic [1:0] t, input logic [3:0] src);
        return {t, 4'h6, src, 10'h2A5};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [FW-1:0] q[$];
    logic [FW-1:0] exp_flits[8];
    int first_valid;
    int n_valid;
    int n_cred_bad;

    initial begin
        vecs[0]  = '{1'b1, rxf(2'b01, 4'h3), 1'b1, 16'd0, 4'h3, 1'b0};
        vecs[1]  = '{1'b1, rxf(2'b00, 4'h0), 1'b1, 16'd0, 4'h3, 1'b0};
        vecs[2]  = '{1'b0, rxf(2'b10, 4'h0), 1'b0, 16'd0, 4'h3, 1'b0};
        vecs[3]  = '{1'b1, rxf(2'b00, 4'h0), 1'b1, 16'd0, 4'h3, 1'b0};
        vecs[4]  = '{1'b1, rxf(2'b10, 4'h0), 1'b1, 16'd1, 4'h3, 1'b0};
        vecs[5]  = '{1'b1, rxf(2'b01, 4'h3), 1'b1, 16'd1, 4'h3, 1'b0};
        vecs[6]  = '{1'b1, rxf(2'b10, 4'h0), 1'b1, 16'd2, 4'h3, 1'b0};
        vecs[7]  = '{1'b0, rxf(2'b01, 4'h7), 1'b0, 16'd2, 4'h3, 1'b0};
        vecs[8]  = '{1'b1, rxf(2'b00, 4'h0), 1'b1, 16'd2, 4'h3, 1'b1};
        vecs[9]  = '{1'b1, rxf(2'b11, 4'hF), 1'b1, 16'd2, 4'h3, 1'b1};
        vecs[10] = '{1'b1, rxf(2'b01, 4'hE), 1'b1, 16'd2, 4'hE, 1'b1};
        vecs[11] = '{1'b1, rxf(2'b10, 4'h0), 1'b1, 16'd3, 4'hE, 1'b1};
        vecs[12] = '{1'b1, rxf(2'b10, 4'h0), 1'b1, 16'd3, 4'hE, 1'b1};
        vecs[13] = '{1'b0, rxf(2'b00, 4'h0), 1'b0, 16'd3, 4'hE, 1'b1};

        // Reset state
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dataout", 32'(dataout), 32'd0);
        chk("rst_credit_cnt", 32'(credit_cnt), 32'd7);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_tx_cnt", 32'(tx_pkt_cnt), 32'd0);
        chk("rst_rx_cnt", 32'(rx_pkt_cnt), 32'd0);
        chk("rst_credit_out", 32'(credit_out), 32'd0);

        // T1: no credits returned, seven flits then stall
        @(negedge clk);
        rst_n = 1'b1;
        gen_en = 1'b1;
        dest_in = 4'h5;
        exp_flits = '{hd(4'h5), bd(16'd0), bd(16'd0), tl(16'd0),
                      hd(4'h5), bd(16'd1), bd(16'd1), tl(16'd1)};
        q.delete();
        first_valid = -1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (out_valid) begin
                if (first_valid < 0) first_valid = t;
                q.push_back(dataout);
            end
        end
        chk("t1_first_valid_cycle", 32'(first_valid), 32'd2);
        chk("t1_flit_count", 32'(q.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("t1_flit%0d", i), (i < q.size()) ? 32'(q[i]) : 32'hDEADBEEF, 32'(exp_flits[i]));
        chk("t1_credit_cnt", 32'(credit_cnt), 32'd0);
        chk("t1_tx_cnt", 32'(tx_pkt_cnt), 32'd1);
        chk("t1_err", 32'(err), 32'd0);

        // T2: a single credit releases exactly one flit (the pending tail)
        @(negedge clk);
        credit_in = 1'b1;
        tick();
        chk("t2_no_emit_on_credit_edge", 32'(out_valid), 32'd0);
        chk("t2_credit_one", 32'(credit_cnt), 32'd1);
        @(negedge clk);
        credit_in = 1'b0;
        tick();
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_flit", 32'(dataout), 32'(tl(16'd1)));
        chk("t2_credit_zero", 32'(credit_cnt), 32'd0);
        chk("t2_tx_cnt", 32'(tx_pkt_cnt), 32'd2);
        n_valid = 0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (out_valid) n_valid++;
        end
        chk("t2_stalled", 32'(n_valid), 32'd0);
        chk("t2_dataout_held", 32'(dataout), 32'(tl(16'd1)));

        // T3: credit returned every cycle, continuous stream
        @(negedge clk);
        rst_n = 1'b0;
        credit_in = 1'b1;
        dest_in = 4'hA;
        @(negedge clk);
        rst_n = 1'b1;
        exp_flits = '{hd(4'hA), bd(16'd0), bd(16'd0), tl(16'd0),
                      hd(4'hA), bd(16'd1), bd(16'd1), tl(16'd1)};
        q.delete();
        n_valid = 0;
        n_cred_bad = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (out_valid) begin
                n_valid++;
                q.push_back(dataout);
            end
            if (credit_cnt != 8'd7) n_cred_bad++;
        end
        chk("t3_valid_cycles", 32'(n_valid), 32'd11);
        chk("t3_credit_steady", 32'(n_cred_bad), 32'd0);
        chk("t3_err_overflow", 32'(err), 32'd1);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t3_flit%0d", i), (i < q.size()) ? 32'(q[i]) : 32'hDEADBEEF, 32'(exp_flits[i]));

        // T6: asynchronous reset in the middle of a body flit
        do_reset();
        tick();
        tick();
        tick();
        chk("t6_pre_body_valid", 32'(out_valid), 32'd1);
        chk("t6_pre_body_flit", 32'(dataout), 32'(bd(16'd0)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid_drop", 32'(out_valid), 32'd0);
        chk("t6_async_dataout", 32'(dataout), 32'd0);
        chk("t6_async_credit", 32'(credit_cnt), 32'd7);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_restart_gap", 32'(out_valid), 32'd0);
        tick();
        chk("t6_restart_valid", 32'(out_valid), 32'd1);
        chk("t6_restart_head", 32'(dataout), 32'(hd(4'hA)));

        // T4/T5: sink vectors with the generator idle
        @(negedge clk);
        gen_en = 1'b0;
        credit_in = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid = vecs[i].v;
            datain = vecs[i].d;
            tick();
            chk($sformatf("rx%0d_credit_out", i), 32'(credit_out), 32'(vecs[i].co));
            chk($sformatf("rx%0d_pkt_cnt", i), 32'(rx_pkt_cnt), 32'(vecs[i].cnt));
            chk($sformatf("rx%0d_last_src", i), 32'(rx_last_src), 32'(vecs[i].src));
            chk($sformatf("rx%0d_err", i), 32'(err), 32'({vecs[i].e1, 1'b0}));
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("rx_tx_quiet", 32'(tx_pkt_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
